glitcbus_clock_ctrl: RTL and testbench
======================================

Name: glitcbus_clock_ctrl

Overview:
Bring-up and supervision sequencer for the GLITC bus clock MMCM (16 MHz GCLK in, 16 MHz deskewed gb_clk out).
- Runs on free-running GCLK, never on the MMCM output.
- Pulses MMCM reset, waits for LOCKED with a timeout, and requires a stability window before releasing the GLITC bus logic reset.
- Re-sequences on lock loss, counts losses, and latches a fault after repeated lock failures.

Parameters:
RST_CYCLES, 16, MMCM reset pulse width in GCLK cycles (>=1)
LOCK_TIMEOUT, 16000, GCLK cycles allowed for LOCKED after reset release (1 ms)
STABLE_CYCLES, 256, consecutive locked cycles required before ready
MAX_RETRIES, 7, failed lock attempts before FAULT (>=1)

Ports:
GCLK  input  1  16 MHz free-running controller clock
nRST  input  1  asynchronous active-low reset
mmcm_locked_i  input  1  MMCM LOCKED, asynchronous to GCLK
restart_i  input  1  single-cycle request to re-sequence from any state
mmcm_rst_o  output  1  MMCM RST, registered
gb_rst_o  output  1  GLITC bus logic reset, active high, registered; consumers synchronize
ready_o  output  1  clock locked and stable
fault_o  output  1  lock never achieved within MAX_RETRIES attempts
state_o  output  3  current state code
retry_count_o  output  4  failed lock attempts since last RUN/restart
lock_loss_count_o  output  8  lock losses from RUN/STABLE, saturating

Behaviour:
- Reset is asynchronous and active-low on nRST, one clock GCLK. Only GCLK-domain logic; no MMCM instantiated here.
- While nRST=0: mmcm_rst_o=1, gb_rst_o=1, ready_o=0, fault_o=0, state_o=RESET, both counters 0, sync FFs 0, timer 0.
- mmcm_locked_i passes through a 2-FF synchronizer (locked_s). Events are evaluated on locked_s.
- States, with state_o encoding:
  - RESET (0):
    - mmcm_rst_o=1, gb_rst_o=1, ready_o=0.
    - Timer counts RST_CYCLES cycles, then goes to WAIT_LOCK with the timer cleared.
  - WAIT_LOCK (1):
    - mmcm_rst_o=0, gb_rst_o=1.
    - locked_s=1: go to STABLE, timer cleared.
    - Otherwise, when the timer reaches LOCK_TIMEOUT-1: retry_count+1.
      - New count == MAX_RETRIES: go to FAULT.
      - Otherwise: go to RESET.
  - STABLE (2):
    - gb_rst_o=1.
    - locked_s=0: lock_loss_count+1 (saturate at 255), go to RESET.
    - Timer reaches STABLE_CYCLES-1 with locked_s=1: go to RUN.
  - RUN (3):
    - gb_rst_o=0, ready_o=1.
    - retry_count cleared on entry.
    - locked_s=0: lock_loss_count+1 (saturate), go to RESET. gb_rst_o=1 and ready_o=0 in the same cycle state_o shows RESET.
  - FAULT (4):
    - mmcm_rst_o=1, gb_rst_o=1, fault_o=1, ready_o=0.
    - Held until restart_i.
- Outputs are registered and decoded from next state, so they change in the same cycle as state_o.
- Latencies:
  - mmcm_locked_i rise to state_o=STABLE: 3 GCLK cycles.
  - mmcm_locked_i fall in RUN to gb_rst_o=1: 3 cycles.
- restart_i:
  - Highest priority, in any state including during RESET: go to RESET, timer cleared, retry_count cleared, fault_o cleared next cycle.
  - lock_loss_count is not cleared.
  - restart_i in the same cycle as a lock event: restart wins, and the lock loss is not counted.
- Counters:
  - retry_count_o saturates at 15.
  - The timer is wide enough for max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) and never wraps; it clears on every state change.
- If locked_s is already 1 on entry to WAIT_LOCK (MMCM did not drop LOCKED), STABLE is entered on the next cycle.
- Unused state codes 5-7 return to RESET.

Test Plan:
- Test parameters for all scenarios: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
- Nominal bring-up: release nRST with locked=0, raise locked 10 cycles after mmcm_rst_o falls.
  - mmcm_rst_o high exactly 4 cycles after reset exit.
  - STABLE entered 3 cycles after the locked rise.
  - RUN, ready_o=1 and gb_rst_o=0 after 8 further cycles.
  - retry_count_o=0.
- Timeout/fault: hold locked=0.
  - Two 20-cycle WAIT_LOCK windows, each preceded by a 4-cycle reset pulse.
  - retry_count_o goes 1, then 2.
  - FAULT with fault_o=1 and mmcm_rst_o=1 held indefinitely.
  - restart_i pulse gives RESET next cycle, fault_o=0, retry_count_o=0.
- Lock loss in RUN: drop locked for 1 cycle.
  - gb_rst_o=1 and ready_o=0 3 cycles later.
  - lock_loss_count_o=1.
  - Full re-sequence back to RUN.
- Glitch in STABLE: drop locked at STABLE cycle 5.
  - Back to RESET, ready_o never asserted, lock_loss_count_o increments.
- Saturation: force 260 lock losses; lock_loss_count_o=255.
- Priority and async reset:
  - restart_i coincident with a locked fall in RUN: RESET with lock_loss_count_o unchanged.
  - nRST low mid-WAIT_LOCK: all outputs reset immediately, without waiting for a GCLK edge.

Source files
------------

// File: rtl/glitcbus_clock_ctrl.sv
// GLITC bus clock MMCM bring-up and supervision sequencer, clocked on the
// free-running 16 MHz GCLK (never on the MMCM output).
//
// Ports:
//   GCLK              free-running controller clock
//   nRST              asynchronous active-low reset
//   mmcm_locked_i     MMCM LOCKED, asynchronous, 2-FF synchronized here
//   restart_i         single-cycle request to re-sequence from any state
//   mmcm_rst_o        MMCM RST, registered
//   gb_rst_o          GLITC bus logic reset, active high, registered
//   ready_o           clock locked and stable
//   fault_o           lock never achieved within MAX_RETRIES attempts
//   state_o           current state code
//   retry_count_o     failed lock attempts since last RUN/restart
//   lock_loss_count_o lock losses from RUN/STABLE, saturating
module glitcbus_clock_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 16000,
  parameter int STABLE_CYCLES = 256,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       GCLK,
  input  logic       nRST,
  input  logic       mmcm_locked_i,
  input  logic       restart_i,
  output logic       mmcm_rst_o,
  output logic       gb_rst_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o,
  output logic [3:0] retry_count_o,
  output logic [7:0] lock_loss_count_o
);

  localparam int TMAX0 =
    (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int TMAX =
    (TMAX0 > STABLE_CYCLES) ? TMAX0 : STABLE_CYCLES;
  localparam int TW = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STAB_LAST = TW'(STABLE_CYCLES - 1);

  localparam logic [3:0] RETRY_LIMIT =
    (MAX_RETRIES > 15) ? 4'd15 : 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  state_t        state_q;
  state_t        state_n;
  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_n;
  logic [TW-1:0] timer_inc;
  logic [3:0]    retry_q;
  logic [3:0]    retry_n;
  logic [3:0]    retry_inc;
  logic [7:0]    loss_q;
  logic [7:0]    loss_n;
  logic [7:0]    loss_inc;
  logic          sync1_q;
  logic          sync2_q;
  logic          locked_s;

  // LOCKED comes from the MMCM with no relation to GCLK.
  always_ff @(posedge GCLK or negedge nRST) begin
    if (!nRST) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= mmcm_locked_i;
      sync2_q <= sync1_q;
    end
  end

  assign locked_s = sync2_q;

  // All counters saturate so they can never wrap.
  always_comb begin
    timer_inc = timer_q;
    if (!(&timer_q)) begin
      timer_inc = timer_q + TW'(1);
    end
  end

  always_comb begin
    retry_inc = retry_q;
    if (!(&retry_q)) begin
      retry_inc = retry_q + 4'd1;
    end
  end

  always_comb begin
    loss_inc = loss_q;
    if (!(&loss_q)) begin
      loss_inc = loss_q + 8'd1;
    end
  end

  always_comb begin
    state_n = state_q;
    timer_n = timer_q;
    retry_n = retry_q;
    loss_n  = loss_q;
    if (restart_i) begin
      // Restart outranks any lock event seen this cycle.
      state_n = ST_RESET;
      timer_n = '0;
      retry_n = '0;
    end else begin
      case (state_q)
        ST_RESET: begin
          if (timer_q == RST_LAST) begin
            state_n = ST_WAIT_LOCK;
            timer_n = '0;
          end else begin
            timer_n = timer_inc;
          end
        end
        ST_WAIT_LOCK: begin
          if (locked_s) begin
            state_n = ST_STABLE;
            timer_n = '0;
          end else if (timer_q == LOCK_LAST) begin
            retry_n = retry_inc;
            timer_n = '0;
            if (retry_inc == RETRY_LIMIT) begin
              state_n = ST_FAULT;
            end else begin
              state_n = ST_RESET;
            end
          end else begin
            timer_n = timer_inc;
          end
        end
        ST_STABLE: begin
          if (!locked_s) begin
            loss_n  = loss_inc;
            state_n = ST_RESET;
            timer_n = '0;
          end else if (timer_q == STAB_LAST) begin
            state_n = ST_RUN;
            timer_n = '0;
            retry_n = '0;
          end else begin
            timer_n = timer_inc;
          end
        end
        ST_RUN: begin
          timer_n = '0;
          if (!locked_s) begin
            loss_n  = loss_inc;
            state_n = ST_RESET;
          end
        end
        ST_FAULT: begin
          timer_n = '0;
        end
        default: begin
          state_n = ST_RESET;
          timer_n = '0;
        end
      endcase
    end
  end

  always_ff @(posedge GCLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_RESET;
      timer_q <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_n;
      timer_q <= timer_n;
      retry_q <= retry_n;
      loss_q  <= loss_n;
    end
  end

  // Decoded from the next state so outputs move with state_o.
  always_ff @(posedge GCLK or negedge nRST) begin
    if (!nRST) begin
      mmcm_rst_o <= 1'b1;
      gb_rst_o   <= 1'b1;
      ready_o    <= 1'b0;
      fault_o    <= 1'b0;
    end else begin
      mmcm_rst_o <= (state_n == ST_RESET) || (state_n == ST_FAULT);
      gb_rst_o   <= (state_n != ST_RUN);
      ready_o    <= (state_n == ST_RUN);
      fault_o    <= (state_n == ST_FAULT);
    end
  end

  assign state_o           = state_q;
  assign retry_count_o     = retry_q;
  assign lock_loss_count_o = loss_q;

endmodule

// File: tb/tb_glitcbus_clock_ctrl.sv
// Self-checking bench for glitcbus_clock_ctrl.
// Per-cycle expected outputs are queued with their stimulus, then drained.
module tb_glitcbus_clock_ctrl;

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAULT  = 3'd4;

  logic       GCLK = 1'b0;
  logic       nRST = 1'b0;
  logic       mmcm_locked_i = 1'b0;
  logic       restart_i = 1'b0;
  logic       mmcm_rst_o;
  logic       gb_rst_o;
  logic       ready_o;
  logic       fault_o;
  logic [2:0] state_o;
  logic [3:0] retry_count_o;
  logic [7:0] lock_loss_count_o;

  typedef struct {
    string       tag;
    logic        lk;
    logic        rs;
    logic [18:0] v;
  } vec_t;

  vec_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exp_llc = 0;

  glitcbus_clock_ctrl #(
    .RST_CYCLES   (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .MAX_RETRIES  (2)
  ) dut (
    .GCLK             (GCLK),
    .nRST             (nRST),
    .mmcm_locked_i    (mmcm_locked_i),
    .restart_i        (restart_i),
    .mmcm_rst_o       (mmcm_rst_o),
    .gb_rst_o         (gb_rst_o),
    .ready_o          (ready_o),
    .fault_o          (fault_o),
    .state_o          (state_o),
    .retry_count_o    (retry_count_o),
    .lock_loss_count_o(lock_loss_count_o)
  );

  always #5 GCLK = ~GCLK;

  function automatic logic [18:0] obs();
    return {state_o, mmcm_rst_o, gb_rst_o, ready_o, fault_o,
            retry_count_o, lock_loss_count_o};
  endfunction

  function automatic logic [18:0] expv(logic [2:0] st,
                                       logic [3:0] rc,
                                       logic [7:0] llc);
    logic mr, gr, rdy, flt;
    mr  = (st == S_RESET) || (st == S_FAULT);
    gr  = (st != S_RUN);
    rdy = (st == S_RUN);
    flt = (st == S_FAULT);
    return {st, mr, gr, rdy, flt, rc, llc};
  endfunction

  function automatic void add(string tag, logic lk, logic rs,
                              logic [2:0] st, logic [3:0] rc);
    vec_t e;
    e.tag = tag;
    e.lk  = lk;
    e.rs  = rs;
    e.v   = expv(st, rc, 8'(exp_llc));
    exp_q.push_back(e);
  endfunction

  // From RUN with LOCKED high: one-cycle LOCKED drop, full re-sequence.
  function automatic void push_loss_block(string tag, logic with_rs);
    add(tag, 1'b0, 1'b0, S_RUN, 4'd0);
    add(tag, 1'b1, 1'b0, S_RUN, 4'd0);
    if (!with_rs && exp_llc < 255) exp_llc++;
    add({tag, "_reset"}, 1'b1, with_rs, S_RESET, 4'd0);
    repeat (3) add(tag, 1'b1, 1'b0, S_RESET, 4'd0);
    add(tag, 1'b1, 1'b0, S_WAIT, 4'd0);
    repeat (8) add(tag, 1'b1, 1'b0, S_STABLE, 4'd0);
    add({tag, "_run"}, 1'b1, 1'b0, S_RUN, 4'd0);
  endfunction

  task automatic test_reset();
    nRST = 1'b0;
    mmcm_locked_i = 1'b0;
    restart_i = 1'b0;
    repeat (3) @(posedge GCLK);
    #1;
    vectors++;
    if (obs() !== expv(S_RESET, 4'd0, 8'd0)) begin
      miscompares++;
      $display("FAIL reset_state: got %05h want %05h",
               obs(), expv(S_RESET, 4'd0, 8'd0));
    end
    nRST = 1'b1;
  endtask

  task automatic test_bringup();
    vec_t e;
    repeat (3) add("bringup_rst_pulse", 1'b0, 1'b0, S_RESET, 4'd0);
    add("bringup_rst_fall", 1'b0, 1'b0, S_WAIT, 4'd0);
    repeat (9) add("bringup_wait", 1'b0, 1'b0, S_WAIT, 4'd0);
    repeat (2) add("bringup_sync", 1'b1, 1'b0, S_WAIT, 4'd0);
    repeat (8) add("bringup_stable", 1'b1, 1'b0, S_STABLE, 4'd0);
    repeat (3) add("bringup_run", 1'b1, 1'b0, S_RUN, 4'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mmcm_locked_i = e.lk;
      restart_i = e.rs;
      @(posedge GCLK);
      #1;
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %05h want %05h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_lock_loss();
    vec_t e;
    push_loss_block("lock_loss", 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mmcm_locked_i = e.lk;
      restart_i = e.rs;
      @(posedge GCLK);
      #1;
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %05h want %05h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_glitch();
    vec_t e;
    add("glitch_restart", 1'b1, 1'b1, S_RESET, 4'd0);
    repeat (3) add("glitch_rst", 1'b1, 1'b0, S_RESET, 4'd0);
    add("glitch_wait", 1'b1, 1'b0, S_WAIT, 4'd0);
    repeat (5) add("glitch_stable", 1'b1, 1'b0, S_STABLE, 4'd0);
    add("glitch_drop", 1'b0, 1'b0, S_STABLE, 4'd0);
    add("glitch_sync", 1'b1, 1'b0, S_STABLE, 4'd0);
    exp_llc++;
    add("glitch_reset", 1'b1, 1'b0, S_RESET, 4'd0);
    repeat (3) add("glitch_rst2", 1'b1, 1'b0, S_RESET, 4'd0);
    add("glitch_wait2", 1'b1, 1'b0, S_WAIT, 4'd0);
    repeat (8) add("glitch_stable2", 1'b1, 1'b0, S_STABLE, 4'd0);
    add("glitch_run", 1'b1, 1'b0, S_RUN, 4'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mmcm_locked_i = e.lk;
      restart_i = e.rs;
      @(posedge GCLK);
      #1;
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %05h want %05h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_timeout_fault();
    vec_t e;
    repeat (2) add("tmo_run", 1'b0, 1'b0, S_RUN, 4'd0);
    exp_llc++;
    repeat (4) add("tmo_rst1", 1'b0, 1'b0, S_RESET, 4'd0);
    repeat (20) add("tmo_wait1", 1'b0, 1'b0, S_WAIT, 4'd0);
    repeat (4) add("tmo_rst2", 1'b0, 1'b0, S_RESET, 4'd1);
    repeat (20) add("tmo_wait2", 1'b0, 1'b0, S_WAIT, 4'd1);
    repeat (12) add("tmo_fault", 1'b0, 1'b0, S_FAULT, 4'd2);
    add("tmo_restart", 1'b0, 1'b1, S_RESET, 4'd0);
    repeat (3) add("tmo_rst3", 1'b1, 1'b0, S_RESET, 4'd0);
    add("tmo_wait3", 1'b1, 1'b0, S_WAIT, 4'd0);
    repeat (8) add("tmo_stable", 1'b1, 1'b0, S_STABLE, 4'd0);
    add("tmo_run2", 1'b1, 1'b0, S_RUN, 4'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mmcm_locked_i = e.lk;
      restart_i = e.rs;
      @(posedge GCLK);
      #1;
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %05h want %05h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_priority();
    vec_t e;
    push_loss_block("priority", 1'b1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mmcm_locked_i = e.lk;
      restart_i = e.rs;
      @(posedge GCLK);
      #1;
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %05h want %05h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_saturation();
    vec_t e;
    for (int i = 0; i < 260; i++) begin
      push_loss_block("saturate", 1'b0);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mmcm_locked_i = e.lk;
      restart_i = e.rs;
      @(posedge GCLK);
      #1;
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %05h want %05h", e.tag, obs(), e.v);
      end
    end
  endtask

  task automatic test_async_reset();
    vec_t e;
    add("async_restart", 1'b0, 1'b1, S_RESET, 4'd0);
    repeat (3) add("async_rst", 1'b0, 1'b0, S_RESET, 4'd0);
    repeat (5) add("async_wait", 1'b0, 1'b0, S_WAIT, 4'd0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      mmcm_locked_i = e.lk;
      restart_i = e.rs;
      @(posedge GCLK);
      #1;
      vectors++;
      if (obs() !== e.v) begin
        miscompares++;
        $display("FAIL %s: got %05h want %05h", e.tag, obs(), e.v);
      end
    end
    #2;
    nRST = 1'b0;
    #1;
    exp_llc = 0;
    vectors++;
    if (obs() !== expv(S_RESET, 4'd0, 8'd0)) begin
      miscompares++;
      $display("FAIL async_reset: got %05h want %05h",
               obs(), expv(S_RESET, 4'd0, 8'd0));
    end
  endtask

  initial begin
    test_reset();
    test_bringup();
    test_lock_loss();
    test_glitch();
    test_timeout_fault();
    test_priority();
    test_saturation();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
